// File: rtl/imm_ext_pipe_ctrl.sv
// Decode-stage controller: classifies the opcode, builds the extended immediate and
// holds up to two decoded entries (main + skid) toward the execute stage.
module imm_ext_pipe_ctrl #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] ILLEGAL_IMM = 32'hFFFF_FFFF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [5:0]      out_extop,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
);

    localparam logic [5:0] EXT_SHAMT = 6'b100000;
    localparam logic [5:0] EXT_I     = 6'b010000;
    localparam logic [5:0] EXT_S     = 6'b001000;
    localparam logic [5:0] EXT_B     = 6'b000100;
    localparam logic [5:0] EXT_U     = 6'b000010;
    localparam logic [5:0] EXT_J     = 6'b000001;
    localparam logic [5:0] EXT_NONE  = 6'b000000;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic [5:0]      extop;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } entry_t;

    state_t state_reg, state_next;
    entry_t main_reg, skid_reg, dec_entry;
    logic   load_main, load_skid, main_from_skid;
    logic   accept, drain;

    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic signed [31:0] imm32;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];

    // Immediate is formed at 32 bits, then sign-extended to XLEN.
    always_comb begin
        dec_entry         = '0;
        dec_entry.inst    = in_inst;
        dec_entry.pc      = in_pc;
        imm32             = '0;
        dec_entry.extop   = EXT_NONE;
        dec_entry.illegal = 1'b0;
        case (opcode)
            7'b0010011: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec_entry.extop = EXT_SHAMT;
                    imm32           = {27'd0, in_inst[24:20]};
                end else begin
                    dec_entry.extop = EXT_I;
                    imm32           = {{20{in_inst[31]}}, in_inst[31:20]};
                end
            end
            7'b0000011, 7'b1100111: begin
                dec_entry.extop = EXT_I;
                imm32           = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            7'b0100011: begin
                dec_entry.extop = EXT_S;
                imm32           = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            7'b1100011: begin
                dec_entry.extop = EXT_B;
                imm32           = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                                   in_inst[30:25], in_inst[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_entry.extop = EXT_U;
                imm32           = {in_inst[31:12], 12'd0};
            end
            7'b1101111: begin
                dec_entry.extop = EXT_J;
                imm32           = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                                   in_inst[20], in_inst[30:21], 1'b0};
            end
            7'b0110011: begin
                dec_entry.extop = EXT_NONE;
                imm32           = '0;
            end
            default: begin
                dec_entry.extop   = EXT_NONE;
                dec_entry.illegal = 1'b1;
            end
        endcase
        dec_entry.imm = dec_entry.illegal ? ILLEGAL_IMM : XLEN'(imm32);
    end

    assign in_ready  = (state_reg != FULL);
    assign out_valid = (state_reg != EMPTY);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    always_comb begin
        state_next     = state_reg;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            // Incoming transfer is dropped; a simultaneous drain is simply consumed.
            state_next = EMPTY;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        state_next = ONE;
                        load_main  = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        state_next = FULL;
                        load_skid  = 1'b1;
                    end else if (drain) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        state_next     = ONE;
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= EMPTY;
            main_reg  <= '0;
            skid_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (load_main) main_reg <= main_from_skid ? skid_reg : dec_entry;
            if (load_skid) skid_reg <= dec_entry;
        end
    end

    assign out_inst    = main_reg.inst;
    assign out_pc      = main_reg.pc;
    assign out_extop   = main_reg.extop;
    assign out_imm     = main_reg.imm;
    assign out_illegal = main_reg.illegal;

endmodule
